// File: rtl/seven_segment_counter_mux_if.sv
// Bus bundle for the multiplexed seven-segment counter: control inputs,
// parallel load data and the display/pulse outputs.
interface seven_segment_counter_mux_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [6:0]            segments;
  logic [DIGITS-1:0]     digit_sel;
  logic                  wrap;
  logic                  tick;

  modport master (
    output en, up, clear, load, load_value,
    input  segments, digit_sel, wrap, tick
  );

  modport slave (
    input  en, up, clear, load, load_value,
    output segments, digit_sel, wrap, tick
  );
endinterface

// File: rtl/seven_segment_counter_mux.sv
// Multi-digit decimal/hex up/down counter with a prescaler, driving a
// time-multiplexed common-segment display (one-hot digit select plus
// shared active-high segments). Optional leading-zero blanking.
module seven_segment_counter_mux #(
  parameter int MAX_COUNT = 1000,
  parameter int DIGITS    = 4,
  parameter int RADIX     = 10,
  parameter int SCAN_DIV  = 64,
  parameter bit BLANK_LZ  = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  seven_segment_counter_mux_if.slave bus
);

  localparam int PW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int IW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(MAX_COUNT - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [3:0]    DIG_MAX    = 4'(RADIX - 1);

  logic [PW-1:0]         presc;
  logic [4*DIGITS-1:0]   count;
  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         scan_idx;
  logic [6:0]            segments_q;
  logic [DIGITS-1:0]     digit_sel_q;
  logic                  tick_q;
  logic                  wrap_q;

  logic                  step;
  logic [4*DIGITS-1:0]   count_step;
  logic                  step_wrap;
  logic [3:0]            dig;
  logic [4*DIGITS-1:0]   load_clean;
  logic                  scan_roll;
  logic [IW-1:0]         scan_idx_nxt;
  logic [3:0]            shown_dig;
  logic                  zero_above;
  logic                  blank;
  logic [6:0]            segments_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  assign step = bus.en && (presc == PRESC_LAST);

  // Next count for a step: ripple carry (up) or borrow (down) through all digits.
  always_comb begin
    count_step = count;
    step_wrap  = 1'b1;
    dig        = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count[4*i +: 4];
      if (step_wrap) begin
        if (bus.up) begin
          if (dig == DIG_MAX) begin
            count_step[4*i +: 4] = 4'd0;
          end else begin
            count_step[4*i +: 4] = dig + 4'd1;
            step_wrap = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            count_step[4*i +: 4] = DIG_MAX;
          end else begin
            count_step[4*i +: 4] = dig - 4'd1;
            step_wrap = 1'b0;
          end
        end
      end
    end
  end

  // Loaded digits outside 0..9 become 0 in decimal mode so the count stays valid BCD.
  always_comb begin
    load_clean = bus.load_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (RADIX == 10 && bus.load_value[4*i +: 4] > 4'd9) begin
        load_clean[4*i +: 4] = 4'd0;
      end
    end
  end

  // Digit to show after this edge, its value and whether it is a blanked leading zero.
  always_comb begin
    scan_roll    = (scan_cnt == SCAN_LAST);
    scan_idx_nxt = scan_idx;
    if (scan_roll) begin
      scan_idx_nxt = (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end
    shown_dig  = 4'd0;
    zero_above = 1'b1;
    blank      = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (count[4*i +: 4] == 4'd0);
      if (IW'(i) == scan_idx_nxt) begin
        shown_dig = count[4*i +: 4];
        blank     = BLANK_LZ && (i > 0) && zero_above;
      end
    end
    segments_nxt = blank ? 7'h00 : glyph(shown_dig);
  end

  // Prescaler and count: clear beats load beats step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      count <= '0;
    end else if (bus.clear) begin
      presc <= '0;
      count <= '0;
    end else if (bus.load) begin
      presc <= '0;
      count <= load_clean;
    end else if (bus.en) begin
      if (step) begin
        presc <= '0;
        count <= count_step;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Tick and wrap pulses, high the cycle after the step edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= step && !bus.clear && !bus.load;
      wrap_q <= step && step_wrap && !bus.clear && !bus.load;
    end
  end

  // Free-running scan; digit select and segments update together so they never disagree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt    <= '0;
      scan_idx    <= '0;
      digit_sel_q <= DIGITS'(1);
      segments_q  <= 7'h3F;
    end else begin
      scan_cnt    <= scan_roll ? '0 : scan_cnt + SW'(1);
      scan_idx    <= scan_idx_nxt;
      digit_sel_q <= DIGITS'(1) << scan_idx_nxt;
      segments_q  <= segments_nxt;
    end
  end

  assign bus.segments  = segments_q;
  assign bus.digit_sel = digit_sel_q;
  assign bus.tick      = tick_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// Three counter configurations driven with the same stimulus; a per-instance
// integer model predicts the outputs after each edge into a queue that a
// monitor drains and compares one cycle later.
module tb_seven_segment_counter_mux;

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] sel;
    logic       tick;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic prev_rst = 1'b0;
  int checks = 0;
  int errors = 0;

  // instance parameters: A decimal 2-digit, B hex 4-digit blanked, C single digit MAX_COUNT=1
  int mc [3] = '{4, 3, 1};
  int nd [3] = '{2, 4, 1};
  int rx [3] = '{10, 16, 10};
  int sd [3] = '{2, 3, 1};
  int bz [3] = '{0, 1, 1};

  int presc [3];
  int cnt   [3];
  int scnt  [3];
  int sidx  [3];
  logic [6:0] glyph [16];

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  seven_segment_counter_mux_if #(.DIGITS(2)) if_a ();
  seven_segment_counter_mux_if #(.DIGITS(4)) if_b ();
  seven_segment_counter_mux_if #(.DIGITS(1)) if_c ();

  seven_segment_counter_mux #(.MAX_COUNT(4), .DIGITS(2), .RADIX(10), .SCAN_DIV(2), .BLANK_LZ(1'b0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  seven_segment_counter_mux #(.MAX_COUNT(3), .DIGITS(4), .RADIX(16), .SCAN_DIV(3), .BLANK_LZ(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  seven_segment_counter_mux #(.MAX_COUNT(1), .DIGITS(1), .RADIX(10), .SCAN_DIV(1), .BLANK_LZ(1'b1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_out(input string nm, input logic [6:0] seg, input logic [7:0] sel,
                         input logic tk, input logic wr, input exp_t e);
    chk({nm, ".segments"}, int'(seg), int'(e.seg));
    chk({nm, ".digit_sel"}, int'(sel), int'(e.sel));
    chk({nm, ".tick"}, int'(tk), int'(e.tick));
    chk({nm, ".wrap"}, int'(wr), int'(e.wrap));
  endtask

  // Reference: the count is a plain integer modulo RADIX**DIGITS.
  function automatic exp_t model_edge(input int k, input bit r, input bit e, input bit u,
                                      input bit c, input bit l, input logic [31:0] lv);
    exp_t x;
    int modv;
    int nidx;
    int d;
    int lvv;
    int nib;
    modv = rx[k] ** nd[k];
    if (!r) begin
      presc[k] = 0; cnt[k] = 0; scnt[k] = 0; sidx[k] = 0;
      x.seg = 7'h3F; x.sel = 8'h01; x.tick = 1'b0; x.wrap = 1'b0;
      return x;
    end
    nidx = (scnt[k] == sd[k] - 1) ? (sidx[k] + 1) % nd[k] : sidx[k];
    d = (cnt[k] / (rx[k] ** nidx)) % rx[k];
    if (bz[k] != 0 && nidx > 0 && cnt[k] < rx[k] ** nidx) x.seg = 7'h00;
    else x.seg = glyph[d];
    x.sel = 8'(1 << nidx);
    scnt[k] = (scnt[k] == sd[k] - 1) ? 0 : scnt[k] + 1;
    sidx[k] = nidx;
    x.tick = 1'b0;
    x.wrap = 1'b0;
    if (c) begin
      cnt[k] = 0; presc[k] = 0;
    end else if (l) begin
      lvv = 0;
      for (int i = 0; i < nd[k]; i++) begin
        nib = int'((lv >> (4 * i)) & 32'hF);
        if (rx[k] == 10 && nib > 9) nib = 0;
        lvv += nib * (rx[k] ** i);
      end
      cnt[k] = lvv; presc[k] = 0;
    end else if (e) begin
      if (presc[k] == mc[k] - 1) begin
        presc[k] = 0;
        x.tick = 1'b1;
        if (u) begin
          if (cnt[k] == modv - 1) begin cnt[k] = 0; x.wrap = 1'b1; end
          else cnt[k] = cnt[k] + 1;
        end else begin
          if (cnt[k] == 0) begin cnt[k] = modv - 1; x.wrap = 1'b1; end
          else cnt[k] = cnt[k] - 1;
        end
      end else begin
        presc[k] = presc[k] + 1;
      end
    end
    return x;
  endfunction

  // Apply one cycle of stimulus and queue the predicted post-edge outputs.
  task automatic cycle(input bit r, input bit e, input bit u, input bit c, input bit l,
                       input logic [31:0] lv);
    @(posedge clk);
    #2;
    rst = r;
    if_a.en = e; if_a.up = u; if_a.clear = c; if_a.load = l; if_a.load_value = lv[7:0];
    if_b.en = e; if_b.up = u; if_b.clear = c; if_b.load = l; if_b.load_value = lv[15:0];
    if_c.en = e; if_c.up = u; if_c.clear = c; if_c.load = l; if_c.load_value = lv[3:0];
    qa.push_back(model_edge(0, r, e, u, c, l, lv));
    qb.push_back(model_edge(1, r, e, u, c, l, lv));
    qc.push_back(model_edge(2, r, e, u, c, l, lv));
    if (!r && prev_rst) begin
      #1;
      chk("async_rst.a.segments", int'(if_a.segments), 'h3F);
      chk("async_rst.a.digit_sel", int'(if_a.digit_sel), 1);
      chk("async_rst.a.wrap", int'(if_a.wrap), 0);
      chk("async_rst.b.segments", int'(if_b.segments), 'h3F);
      chk("async_rst.b.tick", int'(if_b.tick), 0);
    end
    prev_rst = r;
  endtask

  task automatic run(input int n, input bit e, input bit u);
    for (int i = 0; i < n; i++) cycle(1'b1, e, u, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp_out("a", if_a.segments, 8'(if_a.digit_sel), if_a.tick, if_a.wrap, e);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp_out("b", if_b.segments, 8'(if_b.digit_sel), if_b.tick, if_b.wrap, e);
      end
      if (qc.size() > 0) begin
        e = qc.pop_front();
        cmp_out("c", if_c.segments, 8'(if_c.digit_sel), if_c.tick, if_c.wrap, e);
      end
    end
  end

  initial begin : stimulus
    bit r, e, u, c, l;
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    if_a.en = 0; if_a.up = 0; if_a.clear = 0; if_a.load = 0; if_a.load_value = '0;
    if_b.en = 0; if_b.up = 0; if_b.clear = 0; if_b.load = 0; if_b.load_value = '0;
    if_c.en = 0; if_c.up = 0; if_c.clear = 0; if_c.load = 0; if_c.load_value = '0;

    // reset, then count up from zero
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    run(7, 1'b1, 1'b1);
    // async reset mid-count, release with en=1
    repeat (2) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    run(6, 1'b1, 1'b1);
    // decimal up wrap: 98 -> 99 -> 00
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0098);
    run(10, 1'b1, 1'b1);
    // down borrow and down wrap
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0010);
    run(5, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000);
    run(5, 1'b1, 1'b0);
    // clear and load together on a step edge, then a non-BCD load
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000);
    run(3, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0042);
    run(2, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h005A);
    // frozen count, scan only
    run(8, 1'b0, 1'b1);
    // leading-zero blanking
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0007);
    run(12, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000);
    run(12, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0FF9);
    run(40, 1'b1, 1'b1);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) != 0);
      e = ($urandom_range(0, 7) != 0);
      u = ($urandom_range(0, 1) != 0);
      c = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 31) == 0);
      cycle(r, e, u, c, l, $urandom);
    end

    @(posedge clk);
    #3;
    chk("queue_drained", qa.size() + qb.size() + qc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
